// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage controller: control bundle,
// NOP encodings and the stage FSM state type.
package pipe_pkg;

  typedef struct packed {
    logic       rf_we;
    logic       mem_we;
    logic [1:0] wb_sel;
    logic [2:0] br_type;
    logic [4:0] rd;
  } ctrl_t;

  localparam ctrl_t       CTRL_NOP = '0;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Pipeline register: clr loads the NOP pattern, en=0 holds.
// Synchronous active-low reset also loads the NOP pattern.
module pipe_reg #(
  parameter int           W   = 8,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // clear beats hold; hold beats load
  always_ff @(posedge clk) begin
    if (!rstn)    r_q <= NOP;
    else if (clr) r_q <= NOP;
    else if (en)  r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// PC, IF/ID and ID/EX ownership with stall/flush handling.
// Optional PIPE_PERF_EN adds stall-cycle and flush-entry counters.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              STALL_MAX = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_req,
  input  logic            flush_req,
  input  logic [XLEN-1:0] flush_pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [31:0]     inst_in,
  input  ctrl_t           id_ctrl,
  input  logic [2*XLEN-1:0] id_ops,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     if_id_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_vld,
  output ctrl_t           id_ex_ctrl,
  output logic [2*XLEN-1:0] id_ex_ops,
  output logic            id_ex_vld,
  output logic            stall_err
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cyc,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int IFW = 32 + XLEN + 1;
  localparam int EXW = $bits(ctrl_t) + 2*XLEN + 1;
  localparam logic [IFW-1:0] IF_NOP =
    {NOP_INST, {XLEN{1'b0}}, 1'b0};
  localparam logic [EXW-1:0] EX_NOP =
    {CTRL_NOP, {(2*XLEN){1'b0}}, 1'b0};
  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [7:0]      r_cnt;
  logic            r_err;

  logic            w_flush;
  logic            w_stall;
  logic            w_adv;
  logic [7:0]      w_cnt_nxt;
  logic [IFW-1:0]  w_if_q;
  logic [EXW-1:0]  w_ex_q;
  logic            w_if_vld;

  // BOOT/FLUSH are target-fetch cycles with an empty ID stage,
  // so a stall request has nothing to hold there and is ignored.
  assign w_flush   = flush_req;
  assign w_stall   = !flush_req && stall_req &&
                     (r_state == RUN || r_state == STALL);
  assign w_adv     = !w_flush && !w_stall;
  assign w_cnt_nxt = sat_inc8(r_cnt);

  // PC, FSM, stall counter and sticky stall error
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc    <= RESET_PC;
      r_state <= BOOT;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (1'b1)
        w_flush: begin
          r_pc    <= flush_pc;
          r_state <= FLUSH;
          r_cnt   <= '0;
        end
        w_stall: begin
          r_state <= STALL;
          r_cnt   <= w_cnt_nxt;
          if (w_cnt_nxt == STALL_LIM) r_err <= 1'b1;
        end
        default: begin
          r_pc    <= pc_plus4;
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  pipe_reg #(.W(IFW), .NOP(IF_NOP)) u_if_id (
    .clk  (clk),
    .rstn (rstn),
    .en   (w_adv),
    .clr  (w_flush),
    .d    ({inst_in, r_pc, 1'b1}),
    .q    (w_if_q)
  );

  assign w_if_vld = w_if_q[0];

  pipe_reg #(.W(EXW), .NOP(EX_NOP)) u_id_ex (
    .clk  (clk),
    .rstn (rstn),
    .en   (1'b1),
    .clr  (w_flush | w_stall | !w_if_vld),
    .d    ({id_ctrl, id_ops, 1'b1}),
    .q    (w_ex_q)
  );

  assign {if_id_inst, if_id_pc, if_id_vld} = w_if_q;
  assign {id_ex_ctrl, id_ex_ops, id_ex_vld} = w_ex_q;
  assign pc        = r_pc;
  assign stall_err = r_err;

`ifdef PIPE_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_flush) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cyc = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed vector table, then
// randomized traffic checked against a behavioural model.
module tb_pipe_stage_ctrl;
  import pipe_pkg::*;

  localparam int SMAX = 8;

  logic        clk = 1'b0;
  logic        rstn, stall_req, flush_req;
  logic [31:0] flush_pc, pc_plus4, inst_in;
  ctrl_t       id_ctrl;
  logic [63:0] id_ops;
  logic [31:0] pc, if_id_inst, if_id_pc;
  logic        if_id_vld, id_ex_vld, stall_err;
  ctrl_t       id_ex_ctrl;
  logic [63:0] id_ex_ops;
`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  pipe_stage_ctrl #(
    .XLEN(32), .RESET_PC(32'h0), .STALL_MAX(SMAX)
  ) dut (
    .clk(clk), .rstn(rstn),
    .stall_req(stall_req), .flush_req(flush_req),
    .flush_pc(flush_pc), .pc_plus4(pc_plus4),
    .inst_in(inst_in), .id_ctrl(id_ctrl), .id_ops(id_ops),
    .pc(pc), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_vld(if_id_vld), .id_ex_ctrl(id_ex_ctrl),
    .id_ex_ops(id_ex_ops), .id_ex_vld(id_ex_vld),
    .stall_err(stall_err)
`ifdef PIPE_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc)
    , .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] fetch(input logic [31:0] a);
    return {a[24:0], 7'h33};
  endfunction

  // reference model state
  logic [31:0] m_pc = '0, m_ifpc = '0, m_ifi = NOP_INST;
  bit          m_ifv = 0, m_exv = 0, m_err = 0, m_redir = 1;
  ctrl_t       m_exc = '0;
  logic [63:0] m_exo = '0;
  int          m_cnt = 0;
  logic [31:0] m_pst = '0, m_pfl = '0;

  task automatic step(input bit r, s, f, input logic [31:0] fp);
    logic [11:0] c;
    @(negedge clk);
    rstn      = r;
    stall_req = s;
    flush_req = f;
    flush_pc  = fp;
    pc_plus4  = m_pc + 32'd4;
    inst_in   = fetch(m_pc);
    c         = 12'($urandom);
    id_ctrl   = c;
    id_ops    = {$urandom, $urandom};
    @(posedge clk);
    if (!r) begin
      m_pc = '0; m_ifpc = '0; m_ifi = NOP_INST; m_ifv = 0;
      m_exc = '0; m_exo = '0; m_exv = 0;
      m_err = 0; m_cnt = 0; m_redir = 1; m_pst = 0; m_pfl = 0;
    end else if (f) begin
      m_pc = fp; m_ifpc = '0; m_ifi = NOP_INST; m_ifv = 0;
      m_exc = '0; m_exo = '0; m_exv = 0;
      m_cnt = 0; m_redir = 1; m_pfl++;
    end else if (s && !m_redir) begin
      m_exc = '0; m_exo = '0; m_exv = 0;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_cnt >= SMAX) m_err = 1;
      m_pst++;
    end else begin
      if (m_ifv) begin
        m_exc = id_ctrl; m_exo = id_ops; m_exv = 1;
      end else begin
        m_exc = '0; m_exo = '0; m_exv = 0;
      end
      m_ifpc = m_pc; m_ifi = fetch(m_pc); m_ifv = 1;
      m_pc = m_pc + 32'd4;
      m_cnt = 0; m_redir = 0;
    end
    #1;
    chk("pc", 96'(pc), 96'(m_pc));
    chk("if_id_vld", 96'(if_id_vld), 96'(m_ifv));
    chk("if_id_inst", 96'(if_id_inst), 96'(m_ifi));
    if (m_ifv) chk("if_id_pc", 96'(if_id_pc), 96'(m_ifpc));
    chk("id_ex_vld", 96'(id_ex_vld), 96'(m_exv));
    chk("id_ex_ctrl", 96'(id_ex_ctrl), 96'(m_exc));
    if (m_exv) chk("id_ex_ops", 96'(id_ex_ops), 96'(m_exo));
    chk("stall_err", 96'(stall_err), 96'(m_err));
`ifdef PIPE_PERF_EN
    chk("perf_stall", 96'(perf_stall_cyc), 96'(m_pst));
    chk("perf_flush", 96'(perf_flush_cnt), 96'(m_pfl));
`endif
  endtask

  typedef struct {
    bit          r, s, f;
    logic [31:0] fp, pc, ifpc;
    bit          ifv, exv, err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit r, s, f, logic [31:0] fp,
                              logic [31:0] epc, eifpc,
                              bit ifv, exv, err);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.fp = fp;
    v.pc = epc; v.ifpc = eifpc;
    v.ifv = ifv; v.exv = exv; v.err = err;
    return v;
  endfunction

  initial begin
    int burst;
    logic [31:0] rnd;
    rstn = 0; stall_req = 0; flush_req = 0;
    flush_pc = '0; pc_plus4 = '0; inst_in = '0;
    id_ctrl = '0; id_ops = '0;

    // reset, boot, run to pc=0x10
    tv.push_back(mk(0,0,0,0,    32'h00,32'h00,0,0,0));
    tv.push_back(mk(0,0,0,0,    32'h00,32'h00,0,0,0));
    tv.push_back(mk(1,0,0,0,    32'h04,32'h00,1,0,0));
    tv.push_back(mk(1,0,0,0,    32'h08,32'h04,1,1,0));
    tv.push_back(mk(1,0,0,0,    32'h0C,32'h08,1,1,0));
    tv.push_back(mk(1,0,0,0,    32'h10,32'h0C,1,1,0));
    // load-use stall, two cycles
    tv.push_back(mk(1,1,0,0,    32'h10,32'h0C,1,0,0));
    tv.push_back(mk(1,1,0,0,    32'h10,32'h0C,1,0,0));
    tv.push_back(mk(1,0,0,0,    32'h14,32'h10,1,1,0));
    // flush to 0x80
    tv.push_back(mk(1,0,1,32'h80,32'h80,32'h00,0,0,0));
    tv.push_back(mk(1,0,0,0,    32'h84,32'h80,1,0,0));
    tv.push_back(mk(1,0,0,0,    32'h88,32'h84,1,1,0));
    // flush + stall together: flush wins
    tv.push_back(mk(1,1,1,32'h40,32'h40,32'h00,0,0,0));
    tv.push_back(mk(1,0,0,0,    32'h44,32'h40,1,0,0));
    tv.push_back(mk(1,0,0,0,    32'h48,32'h44,1,1,0));
    // back-to-back flush
    tv.push_back(mk(1,0,1,32'h80,32'h80,32'h00,0,0,0));
    tv.push_back(mk(1,0,1,32'hC0,32'hC0,32'h00,0,0,0));
    tv.push_back(mk(1,0,0,0,    32'hC4,32'hC0,1,0,0));
    tv.push_back(mk(1,0,0,0,    32'hC8,32'hC4,1,1,0));
    // stall timeout on the 8th stalled edge
    for (int i = 1; i <= SMAX; i++)
      tv.push_back(mk(1,1,0,0,32'hC8,32'hC4,1,0,(i == SMAX)));
    tv.push_back(mk(1,0,0,0,    32'hCC,32'hC8,1,1,1));
    tv.push_back(mk(1,0,0,0,    32'hD0,32'hCC,1,1,1));
    tv.push_back(mk(0,0,0,0,    32'h00,32'h00,0,0,0));
    // reset in the middle of a stall
    tv.push_back(mk(1,0,0,0,    32'h04,32'h00,1,0,0));
    tv.push_back(mk(1,0,0,0,    32'h08,32'h04,1,1,0));
    tv.push_back(mk(1,1,0,0,    32'h08,32'h04,1,0,0));
    tv.push_back(mk(1,1,0,0,    32'h08,32'h04,1,0,0));
    tv.push_back(mk(0,1,0,0,    32'h00,32'h00,0,0,0));

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].s, tv[i].f, tv[i].fp);
      chk($sformatf("tv%0d pc", i), 96'(pc), 96'(tv[i].pc));
      chk($sformatf("tv%0d if_vld", i),
          96'(if_id_vld), 96'(tv[i].ifv));
      if (tv[i].ifv) begin
        chk($sformatf("tv%0d if_pc", i),
            96'(if_id_pc), 96'(tv[i].ifpc));
        chk($sformatf("tv%0d if_inst", i),
            96'(if_id_inst), 96'(fetch(tv[i].ifpc)));
      end else begin
        chk($sformatf("tv%0d if_nop", i),
            96'(if_id_inst), 96'(NOP_INST));
      end
      chk($sformatf("tv%0d ex_vld", i),
          96'(id_ex_vld), 96'(tv[i].exv));
      chk($sformatf("tv%0d err", i),
          96'(stall_err), 96'(tv[i].err));
    end

    // randomized traffic with stall bursts
    burst = 0;
    for (int n = 0; n < 1500; n++) begin
      if (burst == 0 && $urandom_range(0, 5) == 0)
        burst = $urandom_range(1, 12);
      rnd = $urandom;
      step(($urandom_range(0, 249) != 0),
           (burst > 0),
           ($urandom_range(0, 13) == 0),
           {rnd[31:2], 2'b00});
      if (burst > 0) burst--;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
